// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, grant encoding and the timeout fill pattern.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    // Wide enough for the largest supported timeout (255).
    localparam int TIMER_W = 8;

    // A lone request wins outright; a conflict goes to the port not served last.
    function automatic logic pick_grant(input logic if_req,
                                        input logic d_req,
                                        input logic last_grant);
        logic grant;
        if (if_req && d_req) begin
            grant = (last_grant == GRANT_IF) ? GRANT_D : GRANT_IF;
        end else if (d_req) begin
            grant = GRANT_D;
        end else begin
            grant = GRANT_IF;
        end
        return grant;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Busy-cycle counter for the arbiter; expired marks the last allowed busy cycle.
// Clear has priority over enable so a new transaction always starts from zero.
module arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch and a data port.
// One transaction at a time: grant, wait for ack or timeout, one-cycle ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        err
);

    arb_state_t  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        busy;
    logic        timer_expired;
    logic        grant;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_D);

    arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy),
        .expired (timer_expired)
    );

    // NOTE: every signal driven here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant        = pick_grant(if_req, d_req, last_grant_q);

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    last_grant_d = grant;
                    if (grant == GRANT_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d     = BUSY_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            BUSY_IF, BUSY_D: begin
                // An ack on the expiry cycle still completes normally.
                if (mem_ack) begin
                    state_d = RESP;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_we_q ? 32'd0 : mem_rdata;
                    end
                end else if (timer_expired) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = TIMEOUT_DATA;
                    end else begin
                        d_rdata_d = TIMEOUT_DATA;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // last_grant_q names the port currently being served while busy or responding.
    assign mem_req   = busy;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = (state_q == RESP) && (last_grant_q == GRANT_IF);
    assign d_ready   = (state_q == RESP) && (last_grant_q == GRANT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus a hand-driven handshake.
// Runs with a short timeout so the abort path is reachable in a few cycles.
module tb_mem_arbiter;

    localparam int T_CYC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        mack;
        logic [31:0] mrdata;
    } in_t;

    typedef struct packed {
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        irdy;
        logic [31:0] irdata;
        logic        drdy;
        logic [31:0] drdata;
        logic        err;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic in_t mi(logic rst, logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
                               logic [31:0] daddr, logic [31:0] dwdata, logic mack,
                               logic [31:0] mrdata);
        return '{rst, ireq, iaddr, dreq, dwe, daddr, dwdata, mack, mrdata};
    endfunction

    function automatic out_t mo(logic mreq, logic mwe, logic [31:0] maddr, logic [31:0] mwdata,
                                logic irdy, logic [31:0] irdata, logic drdy, logic [31:0] drdata,
                                logic e);
        return '{mreq, mwe, maddr, mwdata, irdy, irdata, drdy, drdata, e};
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic apply(input in_t v);
        reset     = v.rst;
        if_req    = v.ireq;
        if_addr   = v.iaddr;
        d_req     = v.dreq;
        d_we      = v.dwe;
        d_addr    = v.daddr;
        d_wdata   = v.dwdata;
        mem_ack   = v.mack;
        mem_rdata = v.mrdata;
    endtask

    function automatic out_t sample();
        return '{mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, d_ready, d_rdata, err};
    endfunction

    task automatic wait_mem_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] F1 = 32'h1111_0000;

    initial begin
        bit ok;
        apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset, then a single load answered on the second busy cycle
        vecs.push_back('{mi(1, 0, 0,     0, 0, 0,     0,     0, 0),       mo(0, 0, 0,     0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'h40,  0,     0, 0),       mo(1, 0, 'h40,  0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'h40,  0,     0, 0),       mo(1, 0, 'h40,  0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'h40,  0,     1, 'h1234),  mo(0, 0, 'h40,  0,     0, 0,  1, 'h1234,    0)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 'h40,  0,     0, 0),       mo(0, 0, 'h40,  0,     0, 0,  0, 'h1234,    0)});
        // reset, then held conflict: data, fetch, data
        vecs.push_back('{mi(1, 0, 0,     0, 0, 0,     0,     0, 0),       mo(0, 0, 0,     0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  0, 0),       mo(1, 1, 'h44,  'hAB,  0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  1, 'h5555),  mo(0, 1, 'h44,  'hAB,  0, 0,  1, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  0, 0),       mo(0, 1, 'h44,  'hAB,  0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  0, 0),       mo(1, 0, 'h8,   0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  1, F1),      mo(0, 0, 'h8,   0,     1, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  0, 0),       mo(0, 0, 'h8,   0,     0, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  0, 0),       mo(1, 1, 'h44,  'hAB,  0, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h8,   1, 1, 'h44,  'hAB,  1, 'h77),    mo(0, 1, 'h44,  'hAB,  0, F1, 1, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 0,     0,     0, 0),       mo(0, 1, 'h44,  'hAB,  0, F1, 0, 0,         0)});
        // no ack: abort after exactly T_CYC busy cycles, requester inputs ignored while busy
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'h80,  0,     0, 0),       mo(1, 0, 'h80,  0,     0, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'h80,  0,     0, 0),       mo(1, 0, 'h80,  0,     0, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'hFFF, 0,     0, 0),       mo(1, 0, 'h80,  0,     0, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'hFFF, 0,     0, 0),       mo(1, 0, 'h80,  0,     0, F1, 0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     1, 0, 'hFFF, 0,     0, 0),       mo(0, 0, 'h80,  0,     0, F1, 1, DB,        1)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 0,     0,     0, 0),       mo(0, 0, 'h80,  0,     0, F1, 0, DB,        1)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 0,     0,     1, 'h999),   mo(0, 0, 'h80,  0,     0, F1, 0, DB,        1)});
        // reset clears err; ack on the expiry cycle wins
        vecs.push_back('{mi(1, 0, 0,     0, 0, 0,     0,     0, 0),       mo(0, 0, 0,     0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h100, 0, 0, 0,     0,     0, 0),       mo(1, 0, 'h100, 0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h100, 0, 0, 0,     0,     0, 0),       mo(1, 0, 'h100, 0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h100, 0, 0, 0,     0,     0, 0),       mo(1, 0, 'h100, 0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h100, 0, 0, 0,     0,     0, 0),       mo(1, 0, 'h100, 0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h100, 0, 0, 0,     0,     1, 'hCAFE),  mo(0, 0, 'h100, 0,     1, 'hCAFE, 0, 0,     0)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 0,     0,     0, 0),       mo(0, 0, 'h100, 0,     0, 'hCAFE, 0, 0,     0)});
        // reset in BUSY_D, late ack ignored, fresh fetch, ack in RESP ignored
        vecs.push_back('{mi(0, 0, 0,     1, 1, 'h200, 'h5A,  0, 0),       mo(1, 1, 'h200, 'h5A,  0, 'hCAFE, 0, 0,     0)});
        vecs.push_back('{mi(1, 0, 0,     1, 1, 'h200, 'h5A,  0, 0),       mo(0, 0, 0,     0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 0,     0,     1, 'h1),     mo(0, 0, 0,     0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h300, 0, 0, 0,     0,     0, 0),       mo(1, 0, 'h300, 0,     0, 0,  0, 0,         0)});
        vecs.push_back('{mi(0, 1, 'h300, 0, 0, 0,     0,     1, 'hBEE),   mo(0, 0, 'h300, 0,     1, 'hBEE, 0, 0,      0)});
        vecs.push_back('{mi(0, 0, 0,     0, 0, 0,     0,     1, 'h444),   mo(0, 0, 'h300, 0,     0, 'hBEE, 0, 0,      0)});

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i].in);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 160'(sample()), 160'(vecs[i].exp));
        end

        // handshake driven by reacting to the DUT, with a bounded wait for the grant
        @(negedge clk);
        apply(mi(0, 0, 0, 1, 0, 'h500, 0, 0, 0));
        wait_mem_req(10, ok);
        check("hs_grant_seen", 160'(ok), 160'(1));
        check("hs_mem_addr", 160'(mem_addr), 160'('h500));
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h600D_F00D;
        @(posedge clk);
        #1;
        check("hs_ready_next_cycle", 160'(d_ready), 160'(1));
        check("hs_rdata", 160'(d_rdata), 160'(32'h600D_F00D));
        check("hs_mem_req_dropped", 160'(mem_req), 160'(0));
        @(negedge clk);
        apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("hs_ready_pulse_end", 160'({d_ready, if_ready, err}), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
